// File: rtl/proc_pkg.sv
// Shared core definitions: datapath width, load funct3 encodings and the
// writeback FSM state type.
package proc_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEM,
        WB
    } wb_state_t;

    // One-hot register mask used for scoreboard set/clear.
    function automatic logic [XLEN-1:0] reg_mask(input logic [4:0] idx);
        return {{(XLEN-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: selects the byte/halfword lane of an aligned
// memory word and sign- or zero-extends it according to funct3.
module load_align
    import proc_pkg::*;
(
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        unique case (addr_lo)
            2'd0: byte_lane = mem_rdata[7:0];
            2'd1: byte_lane = mem_rdata[15:8];
            2'd2: byte_lane = mem_rdata[23:16];
            2'd3: byte_lane = mem_rdata[31:24];
        endcase
        // Halfword lane ignores addr_lo[0]; misalignment is handled elsewhere.
        half_lane = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (funct3)
            F3_LB:   result = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_lane};
            F3_LH:   result = {{(XLEN-16){half_lane[15]}}, half_lane};
            F3_LHU:  result = {{(XLEN-16){1'b0}}, half_lane};
            default: result = mem_rdata;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: retires completed instructions, waits for load data,
// drives the register-file write port and keeps the pending-write scoreboard.
module writeback_unit
    import proc_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,

    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic [XLEN-1:0] busy,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_result,
    input  logic            in_is_load,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_addr_lo,

    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,

    output logic [4:0]      rd,
    output logic [XLEN-1:0] write,
    output logic            reg_write,

    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data
);

    wb_state_t       state, state_next;
    logic [4:0]      pend_rd;
    logic [2:0]      pend_funct3;
    logic [1:0]      pend_addr_lo;
    logic [XLEN-1:0] load_data;
    logic            accept;
    logic            take_load;
    logic [4:0]      wb_rd_next;
    logic [XLEN-1:0] wb_data_next;
    logic [XLEN-1:0] set_mask;
    logic [XLEN-1:0] clr_mask;

    load_align u_load_align (
        .mem_rdata (mem_rdata),
        .funct3    (pend_funct3),
        .addr_lo   (pend_addr_lo),
        .result    (load_data)
    );

    assign in_ready = (state != WAIT_MEM);
    assign accept   = in_valid && in_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_next   = state;
        take_load    = 1'b0;
        wb_rd_next   = in_rd;
        wb_data_next = in_result;

        case (state)
            IDLE, WB: begin
                if (accept) begin
                    if (in_is_load) begin
                        state_next = WAIT_MEM;
                        take_load  = 1'b1;
                    end else begin
                        state_next = WB;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_next   = WB;
                    wb_rd_next   = pend_rd;
                    wb_data_next = load_data;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Issue-side set takes priority over the retire-side clear.
    assign set_mask = (issue_valid && issue_rd != 5'd0) ? reg_mask(issue_rd) : '0;
    assign clr_mask = (state == WB) ? reg_mask(rd) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            pend_rd      <= '0;
            pend_funct3  <= '0;
            pend_addr_lo <= '0;
            rd           <= '0;
            write        <= '0;
            reg_write    <= 1'b0;
            busy         <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            state <= state_next;
            if (take_load) begin
                pend_rd      <= in_rd;
                pend_funct3  <= in_funct3;
                pend_addr_lo <= in_addr_lo;
            end
            if (state_next == WB) begin
                rd    <= wb_rd_next;
                write <= wb_data_next;
            end
            reg_write <= (state_next == WB) && (wb_rd_next != 5'd0);
            busy      <= (busy & ~clr_mask) | set_mask;
        end
    end

    assign fwd_valid = reg_write;
    assign fwd_rd    = rd;
    assign fwd_data  = write;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_writeback_unit;
    import proc_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] busy;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_result;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  rd;
    logic [31:0] write;
    logic        reg_write;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    writeback_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .busy        (busy),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rd       (in_rd),
        .in_result   (in_result),
        .in_is_load  (in_is_load),
        .in_funct3   (in_funct3),
        .in_addr_lo  (in_addr_lo),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .rd          (rd),
        .write       (write),
        .reg_write   (reg_write),
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one outstanding load at most, plus the result being
    // written this cycle and a per-register pending flag array.
    bit          m_wait;
    logic [4:0]  m_prd;
    logic [2:0]  m_pf3;
    logic [1:0]  m_plo;
    bit          m_wb;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    bit          m_busy [32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] data, input logic [2:0] f3,
                                             input logic [1:0] lo);
        int unsigned w, b, h;
        int v;
        w = data;
        b = (w >> (8 * lo)) & 32'hFF;
        h = (w >> (16 * (lo / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  begin v = int'(b); if (v >= 128) v -= 256; return v; end
            3'b100:  return b;
            3'b001:  begin v = int'(h); if (v >= 32768) v -= 65536; return v; end
            3'b101:  return h;
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] model_busy_word();
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = m_busy[i];
        return r;
    endfunction

    task automatic model_reset();
        m_wait = 0; m_prd = '0; m_pf3 = '0; m_plo = '0;
        m_wb = 0; m_rd = '0; m_data = '0;
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_edge();
        bit nb [32];
        bit nwb;
        for (int i = 0; i < 32; i++) nb[i] = m_busy[i];
        if (m_wb) nb[m_rd] = 0;
        if (issue_valid && issue_rd != 0) nb[issue_rd] = 1;
        nb[0] = 0;
        nwb = 0;
        if (!m_wait && in_valid) begin
            if (in_is_load) begin
                m_wait = 1; m_prd = in_rd; m_pf3 = in_funct3; m_plo = in_addr_lo;
            end else begin
                nwb = 1; m_rd = in_rd; m_data = in_result;
            end
        end else if (m_wait && mem_rvalid) begin
            nwb = 1; m_wait = 0; m_rd = m_prd;
            m_data = ref_load(mem_rdata, m_pf3, m_plo);
        end
        m_wb = nwb;
        for (int i = 0; i < 32; i++) m_busy[i] = nb[i];
    endtask

    task automatic compare();
        bit exp_we;
        exp_we = m_wb && (m_rd != 0);
        check("in_ready", in_ready, !m_wait);
        check("reg_write", reg_write, exp_we);
        check("fwd_valid", fwd_valid, exp_we);
        check("busy", busy, model_busy_word());
        if (exp_we) begin
            check("rd", rd, m_rd);
            check("write", write, m_data);
            check("fwd_rd", fwd_rd, m_rd);
            check("fwd_data", fwd_data, m_data);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_reg_write"}, reg_write, 0);
        check({tag, "_rd"}, rd, 0);
        check({tag, "_write"}, write, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fwd_valid"}, fwd_valid, 0);
        check({tag, "_fwd_rd"}, fwd_rd, 0);
        check({tag, "_fwd_data"}, fwd_data, 0);
    endtask

    task automatic clear_inputs();
        issue_valid = 0; issue_rd = '0;
        in_valid = 0; in_rd = '0; in_result = '0; in_is_load = 0;
        in_funct3 = '0; in_addr_lo = '0;
        mem_rvalid = 0; mem_rdata = '0;
    endtask

    // Inputs are applied at a falling edge; outputs are checked at the next one.
    task automatic cycle();
        if (issue_valid) check("issue_stall", busy[issue_rd], 0);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare();
        clear_inputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic issue(input logic [4:0] r);
        issue_valid = 1; issue_rd = r;
        cycle();
    endtask

    task automatic send(input logic [4:0] r, input logic [31:0] res, input bit ld,
                        input logic [2:0] f3, input logic [1:0] lo);
        in_valid = 1; in_rd = r; in_result = res; in_is_load = ld;
        in_funct3 = f3; in_addr_lo = lo;
        cycle();
    endtask

    task automatic mem_resp(input logic [31:0] data);
        mem_rvalid = 1; mem_rdata = data;
        cycle();
    endtask

    task automatic do_fmt(input string tag, input logic [2:0] f3, input logic [1:0] lo,
                          input logic [31:0] exp);
        send(5'd7, 32'h0, 1, f3, lo);
        idle(1);
        mem_resp(32'h80FF7F01);
        check(tag, write, exp);
    endtask

    initial begin
        logic [31:0] busy_snap;
        clear_inputs();
        model_reset();
        #1 reset_n = 0;
        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset");
        reset_n = 1;
        idle(1);

        // ALU write to x5
        issue(5'd5);
        send(5'd5, 32'hDEADBEEF, 0, 3'b000, 2'd0);
        check("alu_reg_write", reg_write, 1);
        check("alu_rd", rd, 5);
        check("alu_write", write, 32'hDEADBEEF);
        idle(1);
        check("alu_busy5_cleared", busy[5], 0);

        // Load formatting
        do_fmt("lb_lane3", F3_LB, 2'd3, 32'hFFFFFF80);
        do_fmt("lbu_lane3", F3_LBU, 2'd3, 32'h00000080);
        do_fmt("lh_half1", F3_LH, 2'd2, 32'hFFFF80FF);
        do_fmt("lhu_half0", F3_LHU, 2'd0, 32'h00007F01);
        do_fmt("lh_odd_addr", F3_LH, 2'd3, 32'hFFFF80FF);
        do_fmt("lw_word", F3_LW, 2'd1, 32'h80FF7F01);

        // Long load wait on x7
        issue(5'd7);
        send(5'd7, 32'h0, 1, F3_LW, 2'd0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("wait_in_ready", in_ready, 0);
            check("wait_reg_write", reg_write, 0);
        end
        mem_resp(32'h55AA1234);
        check("wait_wb_rd", rd, 7);
        check("wait_wb_data", write, 32'h55AA1234);
        idle(1);
        check("wait_single_write", reg_write, 0);
        check("wait_ready_after", in_ready, 1);

        // Write to x0 is retired but discarded
        busy_snap = busy;
        send(5'd0, 32'h1234, 0, 3'b000, 2'd0);
        check("x0_no_write", reg_write, 0);
        check("x0_busy_same", busy, busy_snap);
        send(5'd11, 32'hCAFE0011, 0, 3'b000, 2'd0);
        check("x0_next_write", reg_write, 1);
        check("x0_next_rd", rd, 11);

        // Same-cycle set and clear of x9
        send(5'd9, 32'h99, 0, 3'b000, 2'd0);
        issue(5'd9);
        check("race_busy9_set", busy[9], 1);
        issue(5'd0);
        check("issue_x0_ignored", busy[0], 0);

        // Reset while waiting on a load to x3
        issue(5'd3);
        send(5'd3, 32'h0, 1, F3_LW, 2'd0);
        idle(2);
        #2 reset_n = 0;
        #1 check_reset_values("midreset");
        model_reset();
        @(negedge clk);
        reset_n = 1;
        mem_resp(32'hBADBAD00);
        check("midreset_no_write", reg_write, 0);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                logic [4:0] r;
                r = 5'($urandom_range(0, 31));
                if (!m_busy[r]) begin
                    issue_valid = 1; issue_rd = r;
                end
            end
            in_valid   = ($urandom_range(0, 1) == 1);
            in_rd      = 5'($urandom);
            in_result  = $urandom;
            in_is_load = ($urandom_range(0, 2) == 0);
            in_funct3  = 3'($urandom);
            in_addr_lo = 2'($urandom);
            mem_rvalid = ($urandom_range(0, 3) == 0);
            mem_rdata  = $urandom;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
